hazard_sequencer: RTL
=====================

# hazard_sequencer

Pipeline hazard and control-flow sequencer for the 5-stage MIPS core. Sits in ID: detects load-use and branch/jr operand hazards, drives the PC/IF-ID write enables and the ID/EX control-bubble select, and issues the redirect select and IF/ID flush for taken branches, j, jal and jr. Multi-cycle stalls are held by an internal FSM and counter, not re-derived each cycle. Saturating stall and flush event counters support performance debug.

## Interface
- CNT_W, 16, width of the stall_count and flush_count performance counters
- Clk  in  1  clock, rising-edge
- Reset_n  in  1  asynchronous active-low reset
- Hold  in  1  external freeze (memory not ready); highest priority
- IFID_Rs, IFID_Rt  in  5 each  source registers of the instruction in ID
- ID_UsesRt  in  1  ID instruction reads rt (R-type, beq, bne, sw)
- ID_Branch, ID_Jump, ID_JR  in  1 each  decoded control-transfer type in ID
- Branch_Taken  in  1  ID comparator result; valid only when ID_Branch=1
- IDEX_MemRead, IDEX_RegWrite  in  1 each  control bits of the instruction in EX
- IDEX_DestReg  in  5  post-RegDst destination of the EX instruction
- EXMEM_MemRead  in  1  MEM-stage instruction is lw
- EXMEM_DestReg  in  5  destination of the MEM instruction
- PCWrite, IFIDWrite  out  1 each  PC and IF/ID register write enables
- Mux_Select_Stall  out  1  1 = zero RegWrite/MemWrite into ID/EX (bubble)
- IFID_Flush  out  1  clear IF/ID to nop on next edge
- Ctrl_branch_or_jump_taken  out  1  PC input mux select: redirect
- stall_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- Match rules: register 0 never matches. srcmatch(d) = (d==IFID_Rs) | (ID_UsesRt & d==IFID_Rt).
- Required stall length N (evaluated in RUN only):
  - load-use: IDEX_MemRead & srcmatch(IDEX_DestReg) -> N=1, except N=2 when (ID_Branch|ID_JR).
  - branch/jr on ALU result: (ID_Branch|ID_JR) & IDEX_RegWrite & !IDEX_MemRead & srcmatch(IDEX_DestReg) -> N=1.
  - branch/jr on load in MEM: (ID_Branch|ID_JR) & EXMEM_MemRead & srcmatch(EXMEM_DestReg) -> N=1.
  - Multiple rules: N = maximum.
- FSM states: RUN, STALL. Register stall_left (2 bits).
  - RUN, N>0: outputs stall this cycle (Mealy); if N=2 go STALL with stall_left=1, else stay RUN (the re-evaluated hazard will be clear).
  - STALL: outputs stall (Moore); stall_left decrements; at 0 return to RUN. Hazard inputs ignored in STALL.
- Stall outputs: PCWrite=0, IFIDWrite=0, Mux_Select_Stall=1, IFID_Flush=0, Ctrl_branch_or_jump_taken=0.
- Redirect (RUN, N=0, no Hold): taken = ID_Jump | ID_JR | (ID_Branch & Branch_Taken). taken -> Ctrl_branch_or_jump_taken=1, IFID_Flush=1, PCWrite=1, IFIDWrite=1, Mux_Select_Stall=0.
- Normal: PCWrite=1, IFIDWrite=1, Mux_Select_Stall=0, IFID_Flush=0, Ctrl=0.
- Hold=1: PCWrite=0, IFIDWrite=0, Mux_Select_Stall=0, IFID_Flush=0, Ctrl=0; FSM state, stall_left and counters frozen; no hazard evaluation.
- Counters: stall_count +1 each cycle stall outputs are driven; flush_count +1 each cycle IFID_Flush=1; both saturate at 2^CNT_W-1, never wrap.

## Timing
- Reset_n low (async, immediate): state=RUN, stall_left=0, counters=0; outputs forced PCWrite=0, IFIDWrite=0, Mux_Select_Stall=1, IFID_Flush=1, Ctrl=0. First edge after release: normal evaluation.
- Reset mid-STALL: abandons stall immediately, no residual stall cycles.
- Hazard-to-stall latency 0 cycles (combinational in RUN); load-use stall length exactly 1 cycle, load-to-branch exactly 2.
- Redirect and flush asserted in the same cycle as the decode; a stall that cycle suppresses redirect; redirect fires the first non-stall cycle.
- Counter outputs are registered, updated on the edge ending the counted cycle.

## Test plan
- Reset: Reset_n=0 mid-cycle -> outputs immediately at reset values, stall_count=0, flush_count=0.
- lw $2 in EX (IDEX_MemRead=1, IDEX_DestReg=2), add using $2 in ID -> exactly 1 cycle PCWrite=0, Mux_Select_Stall=1; stall_count=1.
- lw $3 in EX, beq $3,$0 in ID with Branch_Taken=1 -> 2 stall cycles (RUN->STALL->RUN), then 1 cycle Ctrl=1, IFID_Flush=1; stall_count=2, flush_count=1.
- jr $31 with IDEX_RegWrite=1, IDEX_DestReg=31 -> 1 stall, then redirect; with IDEX_DestReg=0 instead -> no stall, immediate redirect.
- Hold=1 asserted during STALL for 3 cycles -> all enables 0, stall_left and counters unchanged; resumes remaining stall cycle on Hold=0.
- CNT_W=2: 5 consecutive load-use stalls -> stall_count reaches 3 and stays 3.

Source files
------------

// File: rtl/hazard_sequencer.sv
// ---------------------------------------------------------------------------
// HazardSequencer (hazard_sequencer)
//
// Sits in the ID stage of the 5-stage MIPS core. It finds load-use hazards and
// branch/jr operand hazards, then drives the pipeline enables that stall IF/ID.
// It also issues the PC redirect and the IF/ID flush for taken branches, j,
// jal and jr. A hazard that needs two stall cycles is held by a small FSM plus
// a down-counter, so the second cycle does not depend on the EX/MEM inputs
// staying put. Two saturating counters report stall cycles and flush cycles.
//
// Ports
//   Clk, Reset_n                   rising-edge clock, async active-low reset
//   Hold                           external freeze, overrides everything else
//   IFID_Rs, IFID_Rt, ID_UsesRt    source operands of the instruction in ID
//   ID_Branch, ID_Jump, ID_JR      decoded control-transfer type in ID
//   Branch_Taken                   ID comparator result (meaningful with ID_Branch)
//   IDEX_MemRead, IDEX_RegWrite,
//   IDEX_DestReg                   the instruction currently in EX
//   EXMEM_MemRead, EXMEM_DestReg   the instruction currently in MEM
//   PCWrite, IFIDWrite             PC and IF/ID write enables
//   Mux_Select_Stall               1 = inject a bubble into ID/EX
//   IFID_Flush                     turn IF/ID into a nop on the next edge
//   Ctrl_branch_or_jump_taken      PC mux select for the redirect target
//   stall_count, flush_count       saturating performance counters
// ---------------------------------------------------------------------------
module hazard_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Hold,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_Jump,
    input  logic             ID_JR,
    input  logic             Branch_Taken,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_DestReg,
    input  logic             EXMEM_MemRead,
    input  logic [4:0]       EXMEM_DestReg,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             Mux_Select_Stall,
    output logic             IFID_Flush,
    output logic             Ctrl_branch_or_jump_taken,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [1:0]       stall_left_q, stall_left_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       idex_match;
    logic       exmem_match;
    logic       id_ctl_xfer;
    logic       load_use;
    logic       alu_to_ctl;
    logic       load_to_ctl;
    logic [1:0] need_len;
    logic       taken;
    logic       stall_cycle;
    logic       redirect_cycle;

    // Register $0 is hard-wired to zero, so a write to it never creates a hazard.
    function automatic logic src_match(input logic [4:0] dest,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
    endfunction

    // Hazard detection. Branches and jr compare their operands in ID, so they
    // need their operands one stage earlier than ordinary instructions. A load
    // feeding a branch therefore costs two bubbles, and an ALU result or a
    // load in MEM costs one. When several rules fire, the longest stall wins.
    always_comb begin
        idex_match  = src_match(IDEX_DestReg, IFID_Rs, IFID_Rt, ID_UsesRt);
        exmem_match = src_match(EXMEM_DestReg, IFID_Rs, IFID_Rt, ID_UsesRt);
        id_ctl_xfer = ID_Branch | ID_JR;
        load_use    = IDEX_MemRead & idex_match;
        alu_to_ctl  = id_ctl_xfer & IDEX_RegWrite & ~IDEX_MemRead & idex_match;
        load_to_ctl = id_ctl_xfer & EXMEM_MemRead & exmem_match;
        need_len    = 2'd0;
        if (alu_to_ctl || load_to_ctl) begin
            need_len = 2'd1;
        end
        if (load_use) begin
            need_len = id_ctl_xfer ? 2'd2 : 2'd1;
        end
        taken = ID_Jump | ID_JR | (ID_Branch & Branch_Taken);
    end

    // Cycle classification. In RUN the stall is Mealy: a fresh hazard stalls
    // in the same cycle it is decoded. In STALL the hazard inputs are ignored
    // because the count already says how long to wait. Hold freezes
    // everything, so neither kind of cycle is counted while it is high.
    always_comb begin
        stall_cycle    = 1'b0;
        redirect_cycle = 1'b0;
        if (!Hold) begin
            if (state_q == STALL) begin
                stall_cycle = 1'b1;
            end else if (need_len != 2'd0) begin
                stall_cycle = 1'b1;
            end else begin
                redirect_cycle = taken;
            end
        end
    end

    // Output drive. Reset is checked first and combinationally, so the
    // pipeline sees its safe values at once while Reset_n is low. Those
    // values are: no writes, a bubble and a flush.
    always_comb begin
        PCWrite                   = 1'b1;
        IFIDWrite                 = 1'b1;
        Mux_Select_Stall          = 1'b0;
        IFID_Flush                = 1'b0;
        Ctrl_branch_or_jump_taken = 1'b0;
        if (!Reset_n) begin
            PCWrite          = 1'b0;
            IFIDWrite        = 1'b0;
            Mux_Select_Stall = 1'b1;
            IFID_Flush       = 1'b1;
        end else if (Hold) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (stall_cycle) begin
            PCWrite          = 1'b0;
            IFIDWrite        = 1'b0;
            Mux_Select_Stall = 1'b1;
        end else if (redirect_cycle) begin
            IFID_Flush                = 1'b1;
            Ctrl_branch_or_jump_taken = 1'b1;
        end
    end

    // Next-state logic. Only a two-cycle hazard enters STALL. The first bubble
    // is issued from RUN and stall_left holds the bubbles still owed. A
    // one-cycle hazard stays in RUN: one edge later the producer has moved
    // on, so the re-evaluated hazard is already clear.
    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!Hold) begin
            case (state_q)
                RUN: begin
                    if (need_len == 2'd2) begin
                        state_d      = STALL;
                        stall_left_d = 2'd1;
                    end
                end
                STALL: begin
                    if (stall_left_q <= 2'd1) begin
                        state_d      = RUN;
                        stall_left_d = 2'd0;
                    end else begin
                        stall_left_d = stall_left_q - 2'd1;
                    end
                end
                default: begin
                    state_d      = RUN;
                    stall_left_d = 2'd0;
                end
            endcase
        end
        if (stall_cycle && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (redirect_cycle && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // State and counter registers. An asynchronous reset also drops any stall
    // in progress, so no leftover bubbles follow a reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= RUN;
            stall_left_q <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
